// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the accumulator CPU: fetch, decode, optional
// memory access and write-back, with a bounded wait on the memory acknowledge.
module cpu_ctrl_fsm #(
   parameter int WIDTH   = 8,
   parameter int ADDR_W  = 4,
   parameter int TIMEOUT = 15
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [WIDTH-1:0] instr_i,
   input  logic             zero_flag_i,
   input  logic             mem_ack_i,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic             mem_sel_pc_o,
   output logic             ir_wr_en_o,
   output logic             pc_inc_o,
   output logic             pc_wr_en_o,
   output logic             acc_wr_en_o,
   output logic [1:0]       acc_src_o,
   output logic             alu_op_o,
   output logic             busy_o,
   output logic             halted_o,
   output logic             illegal_o,
   output logic             bus_err_o,
   output logic [2:0]       state_o
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_e;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_STA = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h3;
   localparam logic [3:0] OP_SUB = 4'h4;
   localparam logic [3:0] OP_JMP = 4'h5;
   localparam logic [3:0] OP_JZ  = 4'h6;
   localparam logic [3:0] OP_LDI = 4'h7;
   localparam logic [3:0] OP_HLT = 4'hF;

   // The counter only has to reach TIMEOUT-1: the cycle after that either acks or errors out.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
   logic [3:0]       opcode_q, opcode_d;
   logic [3:0]       instrOp;
   logic             timeoutHit;

   assign instrOp    = instr_i[WIDTH-1 -: 4];
   assign timeoutHit = (TIMEOUT != 0) && (waitCnt_q == LAST_WAIT) && !mem_ack_i;
   assign state_o    = state_q;

   // Operand bits feed the datapath address mux, not the sequencer.
   logic [ADDR_W-1:0] unusedOperand;
   assign unusedOperand = instr_i[ADDR_W-1:0];
   if (WIDTH > 4 + ADDR_W) begin : gPad
      logic [WIDTH-5-ADDR_W:0] unusedPad;
      assign unusedPad = instr_i[WIDTH-5:ADDR_W];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         waitCnt_q <= '0;
         opcode_q  <= '0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
         opcode_q  <= opcode_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      waitCnt_d    = waitCnt_q;
      opcode_d     = opcode_q;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_sel_pc_o = 1'b0;
      ir_wr_en_o   = 1'b0;
      pc_inc_o     = 1'b0;
      pc_wr_en_o   = 1'b0;
      acc_wr_en_o  = 1'b0;
      acc_src_o    = 2'b00;
      alu_op_o     = 1'b0;
      illegal_o    = 1'b0;
      bus_err_o    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_i) state_d = FETCH;
         end
         FETCH: begin
            mem_req_o    = 1'b1;
            mem_sel_pc_o = 1'b1;
            if (mem_ack_i) begin
               ir_wr_en_o = 1'b1;
               pc_inc_o   = 1'b1;
               state_d    = DECODE;
            end else if (timeoutHit) begin
               mem_req_o = 1'b0;
               bus_err_o = 1'b1;
               state_d   = HALT;
            end
         end
         DECODE: begin
            opcode_d = instrOp;
            case (instrOp)
               OP_LDA, OP_STA, OP_ADD, OP_SUB: state_d = MEM;
               OP_LDI: state_d = WB;
               OP_JMP: begin
                  pc_wr_en_o = 1'b1;
                  state_d    = FETCH;
               end
               OP_JZ: begin
                  pc_wr_en_o = zero_flag_i;
                  state_d    = FETCH;
               end
               OP_NOP: state_d = FETCH;
               OP_HLT: state_d = HALT;
               default: begin
                  illegal_o = 1'b1;
                  state_d   = FETCH;
               end
            endcase
         end
         MEM: begin
            mem_req_o = 1'b1;
            mem_we_o  = (opcode_q == OP_STA);
            if (mem_ack_i) begin
               state_d = FETCH;
               if (opcode_q == OP_LDA) begin
                  acc_wr_en_o = 1'b1;
                  acc_src_o   = 2'b00;
               end else if (opcode_q == OP_ADD || opcode_q == OP_SUB) begin
                  acc_wr_en_o = 1'b1;
                  acc_src_o   = 2'b01;
                  alu_op_o    = (opcode_q == OP_SUB);
               end
            end else if (timeoutHit) begin
               mem_req_o = 1'b0;
               mem_we_o  = 1'b0;
               bus_err_o = 1'b1;
               state_d   = HALT;
            end
         end
         WB: begin
            acc_wr_en_o = 1'b1;
            acc_src_o   = 2'b10;
            state_d     = FETCH;
         end
         HALT: begin
            state_d = HALT;
         end
         default: state_d = IDLE;
      endcase

      // Wait count restarts whenever the state changes, so it measures one request only.
      if (state_d != state_q) begin
         waitCnt_d = '0;
      end else if ((state_q == FETCH || state_q == MEM) && !mem_ack_i) begin
         waitCnt_d = waitCnt_q + 1'b1;
      end
   end

   assign busy_o   = (state_q == FETCH) || (state_q == DECODE) || (state_q == MEM) || (state_q == WB);
   assign halted_o = (state_q == HALT);

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_cpu_ctrl_fsm;

   localparam int TIMEOUT = 15;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] instr;
   logic       zero_flag;
   logic       mem_ack;
   logic       mem_req, mem_we, mem_sel_pc, ir_wr_en, pc_inc, pc_wr_en, acc_wr_en;
   logic [1:0] acc_src;
   logic       alu_op, busy, halted, illegal, bus_err;
   logic [2:0] state;
   logic [17:0] dutVec;

   int checks = 0;
   int errors = 0;

   int mSt = 0, mWait = 0, mOpc = 0;
   int nSt = 0, nWait = 0, nOpc = 0;

   cpu_ctrl_fsm #(.WIDTH(8), .ADDR_W(4), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .instr_i(instr),
      .zero_flag_i(zero_flag), .mem_ack_i(mem_ack),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_sel_pc_o(mem_sel_pc),
      .ir_wr_en_o(ir_wr_en), .pc_inc_o(pc_inc), .pc_wr_en_o(pc_wr_en),
      .acc_wr_en_o(acc_wr_en), .acc_src_o(acc_src), .alu_op_o(alu_op),
      .busy_o(busy), .halted_o(halted), .illegal_o(illegal), .bus_err_o(bus_err),
      .state_o(state)
   );

   assign dutVec = {mem_req, mem_we, mem_sel_pc, ir_wr_en, pc_inc, pc_wr_en, acc_wr_en,
                    acc_src, alu_op, busy, halted, illegal, bus_err, state};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Expected outputs for one cycle, derived from the instruction-level rules:
   // phases are numbered as the state port reports them, waited = unacked cycles so far.
   function automatic void modelCycle(input int st, input int waited, input int opc,
                                      input logic [7:0] ins, input logic z, input logic a,
                                      input logic go, output logic [17:0] exp,
                                      output int ost, output int owait, output int oopc);
      logic req = 0, we = 0, selPc = 0, irWr = 0, pcInc = 0, pcWr = 0, accWr = 0;
      logic aluSub = 0, ill = 0, berr = 0;
      logic [1:0] src = 2'b00;
      int op = int'(ins[7:4]);
      bit expired = (TIMEOUT != 0) && (waited + 1 == TIMEOUT) && !a;
      ost  = st;
      oopc = opc;
      case (st)
         0: if (go) ost = 1;
         1: begin
            req = 1; selPc = 1;
            if (a) begin irWr = 1; pcInc = 1; ost = 2; end
            else if (expired) begin req = 0; berr = 1; ost = 5; end
         end
         2: begin
            oopc = op;
            if (op >= 1 && op <= 4) ost = 3;
            else if (op == 7) ost = 4;
            else if (op == 5) begin pcWr = 1; ost = 1; end
            else if (op == 6) begin pcWr = z; ost = 1; end
            else if (op == 0) ost = 1;
            else if (op == 15) ost = 5;
            else begin ill = 1; ost = 1; end
         end
         3: begin
            req = 1; we = (opc == 2);
            if (a) begin
               ost = 1;
               if (opc != 2) begin
                  accWr = 1;
                  src = (opc == 1) ? 2'b00 : 2'b01;
                  aluSub = (opc == 4);
               end
            end else if (expired) begin req = 0; we = 0; berr = 1; ost = 5; end
         end
         4: begin accWr = 1; src = 2'b10; ost = 1; end
         default: ost = st;
      endcase
      owait = (ost != st) ? 0 : (((st == 1 || st == 3) && !a) ? waited + 1 : waited);
      exp = {req, we, selPc, irWr, pcInc, pcWr, accWr, src, aluSub,
             logic'(st >= 1 && st <= 4), logic'(st == 5), ill, berr, 3'(st)};
   endfunction

   // Model state advances on the same edges as the design, and is cleared by reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mSt = 0; mWait = 0; mOpc = 0;
      end else begin
         mSt = nSt; mWait = nWait; mOpc = nOpc;
      end
   end

   always @(negedge clk) begin : cmpBlk
      logic [17:0] expVec;
      if (!rst_n) begin
         expVec = '0; nSt = 0; nWait = 0; nOpc = 0;
      end else begin
         modelCycle(mSt, mWait, mOpc, instr, zero_flag, mem_ack, start, expVec, nSt, nWait, nOpc);
      end
      checkOutput("cycle outputs", 32'(dutVec), 32'(expVec));
   end

   task automatic applyStimulus(input logic s, input logic [7:0] ins, input logic z, input logic a);
      @(posedge clk);
      #1;
      start = s; instr = ins; zero_flag = z; mem_ack = a;
      @(negedge clk);
   endtask

   task automatic doReset();
      @(posedge clk);
      #1;
      rst_n = 1'b0; start = 0; instr = 8'h00; zero_flag = 0; mem_ack = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0; start = 0; instr = 8'h00; zero_flag = 0; mem_ack = 0;
      @(negedge clk);
      checkOutput("reset vector", 32'(dutVec), 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idle state", 32'(state), 32'd0);

      // LDI 3 with ack always present
      applyStimulus(1, 8'h73, 0, 1);  checkOutput("ldi idle", 32'(state), 32'd0);
      applyStimulus(0, 8'h73, 0, 1);  checkOutput("ldi fetch state", 32'(state), 32'd1);
      checkOutput("ldi fetch strobes", 32'({ir_wr_en, pc_inc}), 32'b11);
      applyStimulus(0, 8'h73, 0, 1);  checkOutput("ldi decode", 32'(state), 32'd2);
      applyStimulus(0, 8'h73, 0, 1);  checkOutput("ldi wb", 32'({state, acc_wr_en, acc_src}), {26'd0, 3'd4, 1'b1, 2'b10});
      // ADD 5 with three wait cycles in MEM
      applyStimulus(0, 8'h35, 0, 1);  checkOutput("add fetch", 32'(state), 32'd1);
      applyStimulus(0, 8'h35, 0, 0);  checkOutput("add decode req", 32'({state, mem_req}), {28'd0, 3'd2, 1'b0});
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 8'h35, 0, logic'(k == 3));
         checkOutput("add mem bus", 32'({state, mem_req, mem_sel_pc, mem_we}), {26'd0, 3'd3, 3'b100});
         checkOutput("add mem acc", 32'({acc_wr_en, acc_src, alu_op}), (k == 3) ? 32'b1010 : 32'b0000);
      end
      // JZ taken then not taken
      applyStimulus(0, 8'h6A, 1, 1);  checkOutput("jz fetch", 32'(state), 32'd1);
      applyStimulus(0, 8'h6A, 1, 1);  checkOutput("jz taken", 32'({state, pc_wr_en, pc_inc}), {27'd0, 3'd2, 2'b10});
      applyStimulus(0, 8'h6A, 0, 1);  checkOutput("jz back to fetch", 32'(state), 32'd1);
      applyStimulus(0, 8'h6A, 0, 1);  checkOutput("jz not taken", 32'({state, pc_wr_en}), {28'd0, 3'd2, 1'b0});
      // STA: write request, no accumulator update
      applyStimulus(0, 8'h2A, 0, 1);
      applyStimulus(0, 8'h2A, 0, 0);
      applyStimulus(0, 8'h2A, 0, 1);  checkOutput("sta mem", 32'({state, mem_req, mem_we, acc_wr_en}), {26'd0, 3'd3, 3'b110});
      // Illegal opcode behaves as NOP with a one-cycle flag
      applyStimulus(0, 8'h90, 0, 1);
      applyStimulus(0, 8'h90, 0, 1);  checkOutput("illegal pulse", 32'({state, illegal}), {28'd0, 3'd2, 1'b1});
      applyStimulus(0, 8'hF0, 0, 1);  checkOutput("illegal cleared", 32'({state, illegal}), {28'd0, 3'd1, 1'b0});
      applyStimulus(0, 8'hF0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1, 8'hF0, 0, 1);
         checkOutput("halt holds", 32'({state, halted, busy}), {27'd0, 3'd5, 2'b10});
      end

      // Fetch timeout with no ack at all
      doReset();
      applyStimulus(1, 8'h00, 0, 0);
      for (int k = 1; k <= TIMEOUT; k++) begin
         applyStimulus(0, 8'h00, 0, 0);
         if (k == TIMEOUT - 1) checkOutput("pre-timeout", 32'({mem_req, bus_err}), 32'b10);
      end
      checkOutput("timeout cycle", 32'({state, mem_req, bus_err}), {27'd0, 3'd1, 2'b01});
      applyStimulus(0, 8'h00, 0, 0);
      checkOutput("timeout halt", 32'({state, bus_err, halted}), {27'd0, 3'd5, 2'b01});

      // Ack in the last allowed cycle wins
      doReset();
      applyStimulus(1, 8'h00, 0, 0);
      for (int k = 1; k <= TIMEOUT; k++) applyStimulus(0, 8'h00, 0, logic'(k == TIMEOUT));
      checkOutput("late ack", 32'({bus_err, ir_wr_en}), 32'b01);
      applyStimulus(0, 8'h00, 0, 0);
      checkOutput("late ack decode", 32'(state), 32'd2);

      // Asynchronous reset in the middle of a memory access
      doReset();
      applyStimulus(1, 8'h15, 0, 1);
      applyStimulus(0, 8'h15, 0, 1);
      applyStimulus(0, 8'h15, 0, 0);
      applyStimulus(0, 8'h15, 0, 0);
      checkOutput("mem before reset", 32'({state, mem_req}), {28'd0, 3'd3, 1'b1});
      #2 rst_n = 1'b0;
      #1 checkOutput("async reset", 32'(dutVec), 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1; start = 0;
      @(negedge clk);
      applyStimulus(1, 8'h00, 0, 0);
      applyStimulus(0, 8'h00, 0, 0);
      checkOutput("restart fetch", 32'(state), 32'd1);

      // Randomized traffic, alternating fast and slow memory
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] op;
         logic       slow;
         slow = ((i / 200) % 2) == 1;
         if ((mSt == 5) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 299) == 0)) begin
            @(posedge clk);
            #1 rst_n = 1'b0; start = 0;
            @(posedge clk);
            #1 rst_n = 1'b1;
            @(negedge clk);
         end
         op = 4'($urandom_range(0, 15));
         if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h0;
         applyStimulus(logic'($urandom_range(0, 3) == 0), {op, 4'($urandom_range(0, 15))},
                       logic'($urandom_range(0, 1)),
                       slow ? logic'($urandom_range(0, 7) == 0) : logic'($urandom_range(0, 3) != 0));
      end

      @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
